// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module   : branch_predictor_pkg
// Purpose  : Shared types, history width and counter helper for the predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predictor_pkg;

    localparam int GSHARE_GHSR_WIDTH = 8;

    typedef struct packed {
        logic                         taken;
        logic                         btb_hit;
        logic [31:0]                  btb_addr;
        logic [GSHARE_GHSR_WIDTH-1:0] current_GHSR;
    } branch_predict_type;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // 2-bit saturating counter step; never wraps at either end.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic inc);
        if (inc) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_btb.sv
// ============================================================================
// Module   : bp_btb
// Purpose  : Direct-mapped branch target buffer with tag compare, taken-only
//            allocation and per-index valid clear for the init sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_btb #(
    parameter int ENTRIES = 64
) (
    input  logic                       clk,
    input  logic [31:0]                lookup_pc,
    output logic                       hit,
    output logic [31:0]                target,
    input  logic                       wr_en,
    input  logic [31:0]                wr_pc,
    input  logic [31:0]                wr_target,
    input  logic                       clr_en,
    input  logic [$clog2(ENTRIES)-1:0] clr_idx
);

    localparam int c_IDX_W = $clog2(ENTRIES);
    localparam int c_TAG_W = 30 - c_IDX_W;

    logic               r_valid  [ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_TAG_W-1:0] w_rd_tag;
    logic               w_unused;

    assign w_rd_idx = lookup_pc[c_IDX_W+1:2];
    assign w_wr_idx = wr_pc[c_IDX_W+1:2];
    assign w_rd_tag = lookup_pc[31:c_IDX_W+2];
    assign w_unused = ^{lookup_pc[1:0], wr_pc[1:0]};

    assign hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign target = r_target[w_rd_idx];

    // The sweep and allocation never overlap: allocation is only enabled in RUN.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            r_valid[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            r_valid[w_wr_idx]  <= 1'b1;
            r_tag[w_wr_idx]    <= wr_pc[31:c_IDX_W+2];
            r_target[w_wr_idx] <= wr_target;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Purpose  : Fetch-side predictor: BTB plus 2-bit counter PHT, optional gshare
//            history (define BP_GSHARE_EN), with a post-reset clearing sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES       = 64,
    parameter int PHT_ENTRIES       = 256,
    parameter int GSHARE_GHSR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ready,
    input  logic                         if_valid,
    input  logic [31:0]                  if_pc,
    output branch_predict_type           branch_predict,
    input  logic                         upd_valid,
    input  logic [31:0]                  upd_pc,
    input  logic                         upd_taken,
    input  logic [31:0]                  upd_target,
    input  logic [GSHARE_GHSR_WIDTH-1:0] upd_ghsr,
    input  logic                         upd_flush
);

    localparam int                c_GW        = GSHARE_GHSR_WIDTH;
    localparam int                c_BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam logic [c_GW:0]     c_BTB_LIMIT = BTB_ENTRIES[c_GW:0];
    localparam logic [c_GW-1:0]   c_PHT_LAST  = {c_GW{1'b1}};

    bp_state_e        r_state;
    logic [c_GW-1:0]  r_idx;
    logic [1:0]       r_pht [PHT_ENTRIES];

    logic [c_GW-1:0]  w_ghsr;
    logic [c_GW-1:0]  w_pred_idx;
    logic [c_GW-1:0]  w_upd_idx;
    logic             w_btb_hit;
    logic [31:0]      w_btb_target;
    logic             w_hit;
    logic             w_taken;
    logic             w_upd_en;
    logic             w_clr;

    assign ready    = (r_state == BP_RUN);
    assign w_upd_en = ready & upd_valid;
    assign w_clr    = (r_state == BP_INIT) && ({1'b0, r_idx} < c_BTB_LIMIT);
    assign w_hit    = ready & w_btb_hit;
    assign w_taken  = w_hit & r_pht[w_pred_idx][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BP_INIT;
            r_idx   <= '0;
        end else if (r_state == BP_INIT) begin
            r_idx <= r_idx + c_GW'(1);
            if (r_idx == c_PHT_LAST) begin
                r_state <= BP_RUN;
            end
        end
    end

`ifdef BP_GSHARE_EN
    logic [c_GW-1:0] r_ghsr;

    // A flush restores the history the resolved branch should have produced,
    // so it overrides any speculative shift from the current fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghsr <= '0;
        end else if (w_upd_en && upd_flush) begin
            r_ghsr <= {upd_ghsr[c_GW-2:0], upd_taken};
        end else if (ready && if_valid && w_hit) begin
            r_ghsr <= {r_ghsr[c_GW-2:0], w_taken};
        end
    end

    assign w_ghsr     = r_ghsr;
    assign w_pred_idx = if_pc[c_GW+1:2] ^ r_ghsr;
    assign w_upd_idx  = upd_pc[c_GW+1:2] ^ upd_ghsr;
`else
    logic w_unused_hist;

    assign w_ghsr        = '0;
    assign w_pred_idx    = if_pc[c_GW+1:2];
    assign w_upd_idx     = upd_pc[c_GW+1:2];
    assign w_unused_hist = ^{upd_ghsr, upd_flush, if_valid};
`endif

    always_ff @(posedge clk) begin
        if (r_state == BP_INIT) begin
            r_pht[r_idx] <= 2'b01;
        end else if (w_upd_en) begin
            r_pht[w_upd_idx] <= sat_update(r_pht[w_upd_idx], upd_taken);
        end
    end

    bp_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .lookup_pc (if_pc),
        .hit       (w_btb_hit),
        .target    (w_btb_target),
        .wr_en     (w_upd_en & upd_taken),
        .wr_pc     (upd_pc),
        .wr_target (upd_target),
        .clr_en    (w_clr),
        .clr_idx   (r_idx[c_BTB_IDX_W-1:0])
    );

    always_comb begin
        branch_predict              = '0;
        branch_predict.taken        = w_taken;
        branch_predict.btb_hit      = w_hit;
        branch_predict.btb_addr     = w_hit ? w_btb_target : (if_pc + 32'd4);
        branch_predict.current_GHSR = w_ghsr;
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed bench for branch_predictor (bimodal or BP_GSHARE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;
    import branch_predictor_pkg::*;

`ifdef BP_GSHARE_EN
    localparam bit c_GS = 1'b1;
`else
    localparam bit c_GS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               ready;
    logic               if_valid = 1'b0;
    logic [31:0]        if_pc = 32'h0;
    branch_predict_type bp;
    logic               upd_valid = 1'b0;
    logic [31:0]        upd_pc = 32'h0;
    logic               upd_taken = 1'b0;
    logic [31:0]        upd_target = 32'h0;
    logic [7:0]         upd_ghsr = 8'h0;
    logic               upd_flush = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .ready          (ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .branch_predict (bp),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_ghsr       (upd_ghsr),
        .upd_flush      (upd_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic h,
                        input logic t, input logic [31:0] a);
        if_pc = pc;
        #1;
        chk({tag, ".hit"},   32'(bp.btb_hit), 32'(h));
        chk({tag, ".taken"}, 32'(bp.taken),   32'(t));
        chk({tag, ".addr"},  bp.btb_addr,     a);
        tick();
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic [7:0] g, input logic f);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = t;
        upd_target = tgt;
        upd_ghsr   = g;
        upd_flush  = f;
        tick();
        upd_valid  = 1'b0;
        upd_flush  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst.ready", 32'(ready), 32'd0);
        chk("rst.ghsr", 32'(bp.current_GHSR), 32'd0);
        look("rst", 32'h1000, 1'b0, 1'b0, 32'h1004);
        reset = 1'b0;

        // Init sweep: ready rises on the 256th edge after reset drops
        repeat (200) tick();
        look("init", 32'h100, 1'b0, 1'b0, 32'h104);
        repeat (54) tick();
        chk("init.ready_lo", 32'(ready), 32'd0);
        tick();
        chk("init.ready_hi", 32'(ready), 32'd1);
        look("run.miss", 32'h100, 1'b0, 1'b0, 32'h104);

        // Allocation and counter saturation at PHT index 0x40
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        upd(32'h100, 1'b0, 32'h0,   8'h00, 1'b0);
        look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
        look("dec", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        look("sat_lo", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        look("inc", 32'h100, 1'b1, 1'b1, 32'h200);
        chk("ghsr.idle", 32'(bp.current_GHSR), 32'd0);

        // Alias: same BTB index, different tag
        upd(32'h200, 1'b1, 32'h400, 8'h00, 1'b0);
        look("alias.old", 32'h100, 1'b0, 1'b0, 32'h104);
        look("alias.new", 32'h200, 1'b1, 1'b1, 32'h400);

        // Flush repair with a not-taken resolution
        upd(32'h300, 1'b0, 32'h0, 8'h5A, 1'b1);
        chk("flush.ghsr", 32'(bp.current_GHSR), c_GS ? 32'hB4 : 32'h0);
        look("flush.keep", 32'h200, 1'b1, ~c_GS, 32'h400);
        look("flush.noalloc", 32'h300, 1'b0, 1'b0, 32'h304);

        // Same-cycle hit fetch and flush: flush wins
        if_pc    = 32'h200;
        if_valid = 1'b1;
        #1;
        chk("same.hit", 32'(bp.btb_hit), 32'd1);
        upd(32'h300, 1'b1, 32'h500, 8'h01, 1'b1);
        if_valid = 1'b0;
        chk("same.ghsr", 32'(bp.current_GHSR), c_GS ? 32'h03 : 32'h0);
        look("realloc.new", 32'h300, 1'b1, 1'b0, 32'h500);
        look("realloc.old", 32'h200, 1'b0, 1'b0, 32'h204);

        // Speculative shift on a not-taken hit
        if_pc    = 32'h300;
        if_valid = 1'b1;
        tick();
        if_valid = 1'b0;
        chk("spec.ghsr", 32'(bp.current_GHSR), c_GS ? 32'h06 : 32'h0);

        // Reset mid-RUN; an update during the sweep must be ignored
        reset = 1'b1;
        tick();
        chk("rerst.ready", 32'(ready), 32'd0);
        chk("rerst.ghsr", 32'(bp.current_GHSR), 32'd0);
        reset = 1'b0;
        repeat (199) tick();
        upd(32'h400, 1'b1, 32'h600, 8'hFF, 1'b1);
        chk("init.upd_ghsr", 32'(bp.current_GHSR), 32'd0);
        repeat (55) tick();
        chk("reinit.ready_lo", 32'(ready), 32'd0);
        tick();
        chk("reinit.ready_hi", 32'(ready), 32'd1);
        look("reinit.a", 32'h100, 1'b0, 1'b0, 32'h104);
        look("reinit.b", 32'h300, 1'b0, 1'b0, 32'h304);
        look("reinit.c", 32'h400, 1'b0, 1'b0, 32'h404);
        // Counter back at 01: not-taken then taken leaves it at 01
        upd(32'h100, 1'b0, 32'h0,   8'h00, 1'b0);
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        look("reinit.pht", 32'h100, 1'b1, 1'b0, 32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
